rf2p_fifo_ctrl: RTL and testbench

- Streaming FIFO controller. Drives an external two-port register file: one synchronous write port, one synchronous read port, active-low enables, 1-cycle registered read.
- Wraps the raw memory in valid/ready push and pop interfaces.
- Owns pointers, occupancy, full/empty and the read-latency output buffer.
- Used as the PE input/output FIFO front-end in power-analysis builds.

---
 rtl/rf2p_fifo_ctrl_pkg.sv | 18 +
 rtl/rf2p_fifo_obuf.sv | 52 +++++
 rtl/rf2p_fifo_ctrl.sv | 113 +++++++++++
 tb/tb_rf2p_fifo_ctrl.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf2p_fifo_ctrl_pkg.sv
// Shared definitions for the rf2p_fifo_ctrl FIFO controller.
// Includes the address/counter sizing helper and the memory enable polarities.
package rf2p_fifo_ctrl_pkg;

   localparam logic MEM_EN_ACTIVE = 1'b0;
   localparam logic MEM_EN_IDLE   = 1'b1;

   // Ceiling log2, never below 1 so a width is always legal.
   function automatic int unsigned clogb2(input int unsigned value);
      int unsigned res;
      res = 0;
      while ((64'd1 << res) < 64'(value)) begin
         res++;
      end
      return (res == 0) ? 1 : res;
   endfunction

endpackage

// File: rtl/rf2p_fifo_obuf.sv
// Two-entry output buffer (head + skid) that absorbs the one-cycle read latency
// of the register file so the FIFO can pop every cycle without bubbles.
module rf2p_fifo_obuf #(
   parameter int unsigned L_data = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cap_valid,
   input  logic [L_data-1:0] cap_data,
   input  logic              pop,
   output logic [1:0]        cnt,
   output logic [L_data-1:0] head
);

   logic [1:0]        cnt_q, cnt_d, cnt_kept;
   logic [L_data-1:0] head_q, head_d, skid_q, skid_d;

   always_comb begin
      head_d   = head_q;
      skid_d   = skid_q;
      cnt_kept = cnt_q - {1'b0, pop};
      if (pop) begin
         head_d = skid_q;
      end
      // A captured word lands behind whatever survives this cycle's pop.
      if (cap_valid) begin
         if (cnt_kept == 2'd0) begin
            head_d = cap_data;
         end else begin
            skid_d = cap_data;
         end
      end
      cnt_d = cnt_kept + {1'b0, cap_valid};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      head_q <= head_d;
      skid_q <= skid_d;
   end

   assign cnt  = cnt_q;
   assign head = head_q;

endmodule

// File: rtl/rf2p_fifo_ctrl.sv
// Valid/ready FIFO controller driving an external 2-port register file.
// Define RF2P_FIFO_STATS_EN to add the hwm and ovf_sticky statistics outputs.
module rf2p_fifo_ctrl
   import rf2p_fifo_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned L_data = 17,
   parameter int unsigned L_addr = clogb2(DEPTH),
   parameter int unsigned L_cnt  = clogb2(DEPTH + 3)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [L_data-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [L_data-1:0] out_data,
   output logic              mem_wEn,
   output logic [L_addr-1:0] mem_wAddr,
   output logic [L_data-1:0] mem_wData,
   output logic              mem_rEn,
   output logic [L_addr-1:0] mem_rAddr,
   input  logic [L_data-1:0] mem_rData,
   output logic [L_cnt-1:0]  count
`ifdef RF2P_FIFO_STATS_EN
   ,
   output logic [L_cnt-1:0]  hwm,
   output logic              ovf_sticky
`endif
);

   localparam logic [L_cnt-1:0]  DepthCnt = L_cnt'(DEPTH);
   localparam logic [L_addr-1:0] LastAddr = L_addr'(DEPTH - 1);

   logic [L_addr-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [L_cnt-1:0]  mcnt_q, mcnt_d;
   logic              inflight_q;
   logic [1:0]        obuf_cnt;
   logic              push, pop, rd;

   assign in_ready  = (mcnt_q < DepthCnt) & ~rst;
   assign push      = in_valid & in_ready;
   assign out_valid = (obuf_cnt != 2'd0);
   assign pop       = out_valid & out_ready;
   // obuf_cnt + inflight - pop < 2, rearranged so nothing underflows.
   assign rd = ~rst & (mcnt_q != '0) &
               ((3'(obuf_cnt) + 3'(inflight_q)) < (3'd2 + 3'(pop)));

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         wptr_d = (wptr_q == LastAddr) ? '0 : wptr_q + 1'b1;
      end
      if (rd) begin
         rptr_d = (rptr_q == LastAddr) ? '0 : rptr_q + 1'b1;
      end
      mcnt_d = mcnt_q + L_cnt'(push) - L_cnt'(rd);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         mcnt_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         mcnt_q     <= mcnt_d;
         inflight_q <= rd;
      end
   end

   rf2p_fifo_obuf #(
      .L_data (L_data)
   ) u_obuf (
      .clk       (clk),
      .rst       (rst),
      .cap_valid (inflight_q),
      .cap_data  (mem_rData),
      .pop       (pop),
      .cnt       (obuf_cnt),
      .head      (out_data)
   );

   assign mem_wEn   = push ? MEM_EN_ACTIVE : MEM_EN_IDLE;
   assign mem_wAddr = wptr_q;
   assign mem_wData = in_data;
   assign mem_rEn   = rd ? MEM_EN_ACTIVE : MEM_EN_IDLE;
   assign mem_rAddr = rptr_q;
   assign count     = mcnt_q + L_cnt'(inflight_q) + L_cnt'(obuf_cnt);

`ifdef RF2P_FIFO_STATS_EN
   logic [L_cnt-1:0] hwm_q;
   logic             ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hwm_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         hwm_q <= (count > hwm_q) ? count : hwm_q;
         ovf_q <= ovf_q | (in_valid & ~in_ready);
      end
   end

   assign hwm        = hwm_q;
   assign ovf_sticky = ovf_q;
`endif

endmodule

// File: tb/tb_rf2p_fifo_ctrl.sv
// Self-checking bench for rf2p_fifo_ctrl: 16-deep main instance plus a 12-deep
// instance for non-power-of-two wrap, each backed by a behavioural register file.
module tb_rf2p_fifo_ctrl;

   localparam int D16  = 16;
   localparam int D12  = 12;
   localparam int LD   = 17;
   localparam int LA   = 4;
   localparam int LC   = 5;
   localparam int LC12 = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Main instance
   logic          in_valid = 1'b0, out_ready = 1'b0;
   logic [LD-1:0] in_data = '0;
   logic          in_ready, out_valid, mem_wEn, mem_rEn;
   logic [LD-1:0] out_data, mem_wData, mem_rData;
   logic [LA-1:0] mem_wAddr, mem_rAddr;
   logic [LC-1:0] count;
   // 12-deep instance
   logic            in_valid12 = 1'b0, out_ready12 = 1'b0;
   logic [LD-1:0]   in_data12 = '0;
   logic            in_ready12, out_valid12, mem_wEn12, mem_rEn12;
   logic [LD-1:0]   out_data12, mem_wData12, mem_rData12;
   logic [LA-1:0]   mem_wAddr12, mem_rAddr12;
   logic [LC12-1:0] count12;
`ifdef RF2P_FIFO_STATS_EN
   logic [LC-1:0]   hwm;
   logic            ovf_sticky;
   logic [LC12-1:0] hwm12;
   logic            ovf_sticky12;
`endif

   rf2p_fifo_ctrl #(.DEPTH(D16), .L_data(LD)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .mem_wEn(mem_wEn), .mem_wAddr(mem_wAddr), .mem_wData(mem_wData),
      .mem_rEn(mem_rEn), .mem_rAddr(mem_rAddr), .mem_rData(mem_rData), .count(count)
`ifdef RF2P_FIFO_STATS_EN
      , .hwm(hwm), .ovf_sticky(ovf_sticky)
`endif
   );

   rf2p_fifo_ctrl #(.DEPTH(D12), .L_data(LD)) u_dut12 (
      .clk(clk), .rst(rst), .in_valid(in_valid12), .in_ready(in_ready12),
      .in_data(in_data12), .out_valid(out_valid12), .out_ready(out_ready12),
      .out_data(out_data12), .mem_wEn(mem_wEn12), .mem_wAddr(mem_wAddr12),
      .mem_wData(mem_wData12), .mem_rEn(mem_rEn12), .mem_rAddr(mem_rAddr12),
      .mem_rData(mem_rData12), .count(count12)
`ifdef RF2P_FIFO_STATS_EN
      , .hwm(hwm12), .ovf_sticky(ovf_sticky12)
`endif
   );

   logic [LD-1:0] mem16 [D16];
   logic [LD-1:0] mem12 [D12];
   always @(posedge clk) begin
      if (!mem_wEn) mem16[mem_wAddr] <= mem_wData;
      if (!mem_rEn) mem_rData <= mem16[mem_rAddr];
      if (!mem_wEn12) mem12[mem_wAddr12] <= mem_wData12;
      if (!mem_rEn12) mem_rData12 <= mem12[mem_rAddr12];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard and model state for the main instance
   logic [LD-1:0] q [$];
   logic [LD-1:0] exp_word, last_pop_data;
   int exp_w = 0, exp_r = 0, mcnt_m = 0, writes = 0, pops = 0;
   int first_push_cyc = -1, first_pop_cyc = -1, last_pop_cyc = -1;

   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         exp_w = 0; exp_r = 0; mcnt_m = 0;
      end else begin
         chk("count", 32'(count), 32'(q.size()));
         chk("in_ready", 32'(in_ready), 32'(mcnt_m < D16));
         chk("wen_iff_push", 32'(mem_wEn), 32'(!(in_valid && in_ready)));
         if (!mem_wEn) begin
            chk("wr_not_full", 32'(mcnt_m < D16), 32'(1));
            chk("waddr", 32'(mem_wAddr), 32'(exp_w));
            chk("wdata", 32'(mem_wData), 32'(in_data));
            exp_w = (exp_w == D16 - 1) ? 0 : exp_w + 1;
            writes++;
         end
         if (!mem_rEn) begin
            chk("rd_not_empty", 32'(mcnt_m > 0), 32'(1));
            chk("raddr", 32'(mem_rAddr), 32'(exp_r));
            exp_r = (exp_r == D16 - 1) ? 0 : exp_r + 1;
         end
         mcnt_m = mcnt_m + (mem_wEn ? 0 : 1) - (mem_rEn ? 0 : 1);
         if (out_valid && out_ready) begin
            chk("pop_nonempty", 32'(q.size() != 0), 32'(1));
            if (q.size() != 0) begin
               exp_word = q.pop_front();
               chk("pop_data", 32'(out_data), 32'(exp_word));
            end
            last_pop_data = out_data;
            pops++;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
         if (in_valid && in_ready) begin
            q.push_back(in_data);
            if (first_push_cyc < 0) first_push_cyc = cyc;
         end
      end
   end

   // Scoreboard for the 12-deep instance
   logic [LD-1:0] q12 [$];
   logic [LD-1:0] exp_word12;
   int exp_w12 = 0, exp_r12 = 0, writes12 = 0, pops12 = 0;

   always @(negedge clk) begin
      if (rst) begin
         q12.delete();
         exp_w12 = 0; exp_r12 = 0;
      end else begin
         chk("count12", 32'(count12), 32'(q12.size()));
         if (!mem_wEn12) begin
            chk("waddr12", 32'(mem_wAddr12), 32'(exp_w12));
            exp_w12 = (exp_w12 == D12 - 1) ? 0 : exp_w12 + 1;
            writes12++;
         end
         if (!mem_rEn12) begin
            chk("raddr12", 32'(mem_rAddr12), 32'(exp_r12));
            exp_r12 = (exp_r12 == D12 - 1) ? 0 : exp_r12 + 1;
         end
         if (out_valid12 && out_ready12) begin
            chk("pop12_nonempty", 32'(q12.size() != 0), 32'(1));
            if (q12.size() != 0) begin
               exp_word12 = q12.pop_front();
               chk("pop12_data", 32'(out_data12), 32'(exp_word12));
            end
            pops12++;
         end
         if (in_valid12 && in_ready12) q12.push_back(in_data12);
      end
   end

   int n_acc = 0;
   int data_base = 0;
   bit rand_data = 1'b0;

   // One clock of the main push driver; new data only once the word was taken.
   task automatic step();
      logic acc;
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
         n_acc++;
         in_data = rand_data ? LD'($urandom) : LD'(data_base + n_acc);
      end
   endtask

   task automatic clear_stats();
      n_acc = 0; pops = 0; writes = 0;
      first_push_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
   endtask

   initial begin
      logic acc;
      int   guard;
      int   n12;

      // Reset state, with in_valid high to show the push is blocked
      in_valid = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_count", 32'(count), 32'(0));
      chk("rst_wen", 32'(mem_wEn), 32'(1));
      chk("rst_ren", 32'(mem_rEn), 32'(1));
      @(posedge clk); #1;
      rst = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk); #1;

      // Fill to full with the consumer stalled
      clear_stats();
      data_base = 0; in_data = '0; in_valid = 1'b1; out_ready = 1'b0;
      repeat (40) step();
      chk("fill_accepted", 32'(n_acc), 32'(18));
      chk("fill_writes", 32'(writes), 32'(18));
      chk("fill_count", 32'(count), 32'(18));
      chk("fill_in_ready", 32'(in_ready), 32'(0));
`ifdef RF2P_FIFO_STATS_EN
      chk("fill_hwm", 32'(hwm), 32'(18));
      chk("fill_ovf", 32'(ovf_sticky), 32'(1));
`endif
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (30) step();
      chk("drain_pops", 32'(pops), 32'(18));
      chk("drain_last", 32'(last_pop_data), 32'(17));
      chk("drain_count", 32'(count), 32'(0));
      chk("drain_out_valid", 32'(out_valid), 32'(0));

      // Back-to-back streaming: latency 3, then no bubbles
      clear_stats();
      data_base = 1; in_data = LD'(1); in_valid = 1'b1; out_ready = 1'b1;
      guard = 0;
      while (n_acc < 100 && guard < 300) begin
         step();
         guard++;
      end
      in_valid = 1'b0;
      repeat (10) step();
      chk("stream_push_cycles", 32'(guard), 32'(100));
      chk("stream_pops", 32'(pops), 32'(100));
      chk("stream_latency", 32'(first_pop_cyc - first_push_cyc), 32'(3));
      chk("stream_no_gaps", 32'(last_pop_cyc - first_pop_cyc), 32'(99));
      chk("stream_last", 32'(last_pop_data), 32'(100));

      // Random stalls on both sides
      clear_stats();
      rand_data = 1'b1; in_data = LD'($urandom);
      guard = 0;
      while (n_acc < 1000 && guard < 20000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         step();
         guard++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (30) step();
      rand_data = 1'b0;
      chk("rand_accepted", 32'(n_acc), 32'(1000));
      chk("rand_pops", 32'(pops), 32'(1000));

      // Reset mid-operation with 7 words held and a read in flight
      clear_stats();
      data_base = 'h300; in_data = LD'('h300); in_valid = 1'b1; out_ready = 1'b0;
      guard = 0;
      while (n_acc < 9 && guard < 50) begin
         step();
         guard++;
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("mid_count9", 32'(count), 32'(9));
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("mid_count7", 32'(count), 32'(7));
      chk("mid_rst_ren", 32'(mem_rEn), 32'(1));
      chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_out_valid", 32'(out_valid), 32'(0));
      chk("mid_count0", 32'(count), 32'(0));
      chk("mid_wen", 32'(mem_wEn), 32'(1));
      chk("mid_ren", 32'(mem_rEn), 32'(1));
      @(posedge clk); #1;
      clear_stats();
      in_valid = 1'b1; in_data = LD'('hA5); out_ready = 1'b1;
      @(negedge clk);
      chk("a5_wen", 32'(mem_wEn), 32'(0));
      chk("a5_waddr", 32'(mem_wAddr), 32'(0));
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 10 && pops == 0; i++) step();
      chk("a5_pops", 32'(pops), 32'(1));
      chk("a5_data", 32'(last_pop_data), 32'('hA5));
      chk("a5_latency", 32'(first_pop_cyc - first_push_cyc), 32'(3));
`ifdef RF2P_FIFO_STATS_EN
      chk("a5_hwm", 32'(hwm), 32'(1));
      chk("a5_ovf", 32'(ovf_sticky), 32'(0));
`endif

      // Non-power-of-two depth wrap on the 12-deep instance
      n12 = 0;
      in_data12 = LD'(200); in_valid12 = 1'b1; out_ready12 = 1'b1;
      for (int i = 0; i < 200 && n12 < 40; i++) begin
         @(negedge clk);
         acc = in_valid12 & in_ready12;
         @(posedge clk); #1;
         if (acc) begin
            n12++;
            in_data12 = LD'(200 + n12);
         end
      end
      in_valid12 = 1'b0;
      repeat (10) step();
      chk("d12_accepted", 32'(n12), 32'(40));
      chk("d12_writes", 32'(writes12), 32'(40));
      chk("d12_pops", 32'(pops12), 32'(40));
      chk("d12_count", 32'(count12), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
